// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared types and constants for the LBP window sequencer
// Purpose: FSM state encoding, window row offsets and read counts used by
//          lbp_window_sequencer and lbp_scan_counter.
// Ports:   none (package)
package lbp_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Row offset inside the 3x3 window; also the read index within a column.
   localparam logic [1:0] ROW_TOP = 2'd0;
   localparam logic [1:0] ROW_CTR = 2'd1;
   localparam logic [1:0] ROW_BOT = 2'd2;

   // Reads needed to fill a fresh window vs. to slide it one column right.
   localparam logic [3:0] PRIME_READS = 4'd9;
   localparam logic [3:0] STEP_READS  = 4'd3;

endpackage

// File: rtl/lbp_window_sequencer_scan.sv
// rtl/lbp_window_sequencer_scan.sv - row/column/read-index counters and address formation
// Purpose: holds the centre row r, column pointer c and in-column read index k,
//          forms the gray read address and the result (centre) address.
// Ports:   clk, reset (async active-low)
//          start_frame - load r=1, c=0, k=0
//          next_row    - r++, c=0, k=0
//          rd_acc      - a gray read was accepted: advance k, and c on k wrap
//          rd_en       - enables gray_addr (READ state), else 0
//          emit_en     - enables lbp_addr (EMIT state), else 0
//          k           - current read index (window row of the next read)
//          gray_addr   - {r-1+k, c}
//          lbp_addr    - {r, c-2}
//          row_end     - c has passed the last column
//          frame_end   - row_end on the last interior row
module lbp_scan_counter
   import lbp_pkg::*;
#(
   parameter int W_LOG2 = 7,
   parameter int H_LOG2 = 7,
   parameter int ADDR_W = W_LOG2 + H_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_frame,
   input  logic              next_row,
   input  logic              rd_acc,
   input  logic              rd_en,
   input  logic              emit_en,
   output logic [1:0]        k,
   output logic [ADDR_W-1:0] gray_addr,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic              row_end,
   output logic              frame_end
);

   localparam logic [H_LOG2-1:0] R_FIRST = H_LOG2'(1);
   localparam logic [H_LOG2-1:0] R_LAST  = H_LOG2'((1 << H_LOG2) - 2);

   logic [H_LOG2-1:0] r;
   // One extra bit: c runs 0..2^W_LOG2, the top value marking end of row.
   logic [W_LOG2:0]   c;
   logic [H_LOG2-1:0] row_rd;
   logic [W_LOG2-1:0] col_ctr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r <= '0;
         c <= '0;
         k <= ROW_TOP;
      end else if (start_frame) begin
         r <= R_FIRST;
         c <= '0;
         k <= ROW_TOP;
      end else if (next_row) begin
         r <= r + R_FIRST;
         c <= '0;
         k <= ROW_TOP;
      end else if (rd_acc) begin
         if (k == ROW_BOT) begin
            k <= ROW_TOP;
            c <= c + (W_LOG2 + 1)'(1);
         end else begin
            k <= k + 2'd1;
         end
      end
   end

   assign row_rd  = r - H_LOG2'(ROW_CTR) + H_LOG2'(k);
   // Modulo arithmetic on the low bits is enough: c is in 2..2^W_LOG2 here.
   assign col_ctr = c[W_LOG2-1:0] - W_LOG2'(2);

   assign gray_addr = rd_en   ? {row_rd, c[W_LOG2-1:0]} : '0;
   assign lbp_addr  = emit_en ? {r, col_ctr}            : '0;
   assign row_end   = c[W_LOG2];
   assign frame_end = row_end && (r == R_LAST);

endmodule

// File: rtl/lbp_window_sequencer.sv
// rtl/lbp_window_sequencer.sv - frame sequencer feeding the LBP window datapath
// Purpose: walks every interior pixel in raster order, issues column-major gray
//          reads to fill/slide the 3x3 window, strobes returned pixels into the
//          datapath and presents each LBP result with its centre address.
// Ports:   clk, reset (async active-low), start
//          gray_req/gray_addr/gray_ready - gray memory read port
//          pix_we/pix_row                - datapath window write strobe, row offset
//          lbp_valid/lbp_addr/lbp_ready  - result handshake
//          busy, finish                  - status
module lbp_window_sequencer
   import lbp_pkg::*;
#(
   parameter int W_LOG2 = 7,
   parameter int H_LOG2 = 7,
   parameter int ADDR_W = W_LOG2 + H_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic              gray_ready,
   output logic              pix_we,
   output logic [1:0]        pix_row,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   input  logic              lbp_ready,
   output logic              busy,
   output logic              finish
);

   state_t     state, state_nxt;
   logic [3:0] n;
   logic       start_frame, next_row, rd_acc, load_step;
   logic [1:0] k;
   logic       row_end, frame_end;

   lbp_scan_counter #(
      .W_LOG2 (W_LOG2),
      .H_LOG2 (H_LOG2),
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk         (clk),
      .reset       (reset),
      .start_frame (start_frame),
      .next_row    (next_row),
      .rd_acc      (rd_acc),
      .rd_en       (state == READ),
      .emit_en     (state == EMIT),
      .k           (k),
      .gray_addr   (gray_addr),
      .lbp_addr    (lbp_addr),
      .row_end     (row_end),
      .frame_end   (frame_end)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      gray_req    = 1'b0;
      lbp_valid   = 1'b0;
      finish      = 1'b0;
      start_frame = 1'b0;
      next_row    = 1'b0;
      rd_acc      = 1'b0;
      load_step   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_frame = 1'b1;
               state_nxt   = READ;
            end
         end
         READ: begin
            gray_req = 1'b1;
            if (gray_ready) begin
               rd_acc = 1'b1;
               if (n == 4'd1) state_nxt = DRAIN;
            end
         end
         DRAIN: state_nxt = EMIT;
         EMIT: begin
            lbp_valid = 1'b1;
            if (lbp_ready) begin
               if (!row_end) begin
                  load_step = 1'b1;
                  state_nxt = READ;
               end else if (!frame_end) begin
                  next_row  = 1'b1;
                  state_nxt = READ;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Remaining reads before the window is complete.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        n <= '0;
      else if (start_frame || next_row)  n <= PRIME_READS;
      else if (load_step)                n <= STEP_READS;
      else if (rd_acc)                   n <= n - 4'd1;
   end

   // Memory returns data one cycle after accept; strobe it with the row it came from.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_we  <= 1'b0;
         pix_row <= ROW_TOP;
      end else begin
         pix_we  <= rd_acc;
         pix_row <= rd_acc ? k : ROW_TOP;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_lbp_window_sequencer.sv
// tb/tb_lbp_window_sequencer.sv - self-checking bench for lbp_window_sequencer
module tb_lbp_window_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small 4x4 instance
   logic       s_reset, s_start, s_gray_req, s_gray_ready, s_pix_we;
   logic [3:0] s_gray_addr, s_lbp_addr;
   logic [1:0] s_pix_row;
   logic       s_lbp_valid, s_lbp_ready, s_busy, s_finish;

   // Default 128x128 instance
   logic        b_reset, b_start, b_gray_req, b_gray_ready, b_pix_we;
   logic [13:0] b_gray_addr, b_lbp_addr;
   logic [1:0]  b_pix_row;
   logic        b_lbp_valid, b_lbp_ready, b_busy, b_finish;

   lbp_window_sequencer #(.W_LOG2(2), .H_LOG2(2)) u_small (
      .clk(clk), .reset(s_reset), .start(s_start),
      .gray_req(s_gray_req), .gray_addr(s_gray_addr), .gray_ready(s_gray_ready),
      .pix_we(s_pix_we), .pix_row(s_pix_row),
      .lbp_valid(s_lbp_valid), .lbp_addr(s_lbp_addr), .lbp_ready(s_lbp_ready),
      .busy(s_busy), .finish(s_finish)
   );

   lbp_window_sequencer u_big (
      .clk(clk), .reset(b_reset), .start(b_start),
      .gray_req(b_gray_req), .gray_addr(b_gray_addr), .gray_ready(b_gray_ready),
      .pix_we(b_pix_we), .pix_row(b_pix_row),
      .lbp_valid(b_lbp_valid), .lbp_addr(b_lbp_addr), .lbp_ready(b_lbp_ready),
      .busy(b_busy), .finish(b_finish)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Gray accepts in order, results encoded as 100+lbp_addr.
   int exp_seq [28] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 105,
                        3, 7, 11, 106,
                        4, 8, 12, 5, 9, 13, 6, 10, 14, 109,
                        7, 11, 15, 110};

   int got_q [$];
   int first_valid_cyc, second_valid_cyc, first_acc_cyc;
   int n_fin, busy_after, hold_bad, hold_cnt, hold_addr_bad, pix_bad, overlap_bad;
   int read_after_acc, first_read_addr, accepts;

   // Big-frame monitor
   int b_cnt = 0, b_last = -1, b_fin = 0;
   always @(negedge clk) begin
      if (b_lbp_valid && b_lbp_ready) begin
         b_cnt  <= b_cnt + 1;
         b_last <= int'(b_lbp_addr);
      end
      if (b_finish) b_fin <= b_fin + 1;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_small(input bit stall, input bit hold, input bit poke, input int abort_after);
      bit prev_acc, prev_stalled, prev_valid;
      int prev_addr, prev_k;
      got_q.delete();
      first_valid_cyc = -1; second_valid_cyc = -1; first_acc_cyc = -1;
      n_fin = 0; busy_after = -1; hold_bad = 0; hold_cnt = 0; hold_addr_bad = 0;
      pix_bad = 0; overlap_bad = 0; read_after_acc = -1; first_read_addr = -1; accepts = 0;
      prev_acc = 0; prev_stalled = 0; prev_valid = 0; prev_addr = 0; prev_k = 0;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         s_gray_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s_lbp_ready  = 1'b1;
         if (hold && s_lbp_valid && hold_cnt < 20) begin
            s_lbp_ready = 1'b0;
            hold_cnt++;
            if (s_lbp_addr !== 4'd5 || s_gray_req !== 1'b0) hold_bad++;
         end
         s_start = poke && (cyc == 5 || cyc == 30);
         #1;
         if (prev_stalled && s_gray_req && int'(s_gray_addr) != prev_addr) hold_addr_bad++;
         if (s_pix_we !== prev_acc) pix_bad++;
         if (s_pix_we && int'(s_pix_row) != prev_k) pix_bad++;
         if (s_gray_req && s_lbp_valid) overlap_bad++;
         if (s_finish && s_lbp_valid) overlap_bad++;
         if (s_lbp_valid && !prev_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            else if (second_valid_cyc < 0) second_valid_cyc = cyc;
         end
         if (first_acc_cyc >= 0 && read_after_acc < 0 && s_gray_req) begin
            read_after_acc  = cyc - first_acc_cyc;
            first_read_addr = int'(s_gray_addr);
         end
         prev_acc = s_gray_req && s_gray_ready;
         prev_k   = accepts % 3;
         if (prev_acc) begin
            got_q.push_back(int'(s_gray_addr));
            accepts++;
         end
         prev_stalled = s_gray_req && !s_gray_ready;
         prev_addr    = int'(s_gray_addr);
         if (s_lbp_valid && s_lbp_ready) begin
            got_q.push_back(100 + int'(s_lbp_addr));
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
         end
         if (s_finish) n_fin++;
         prev_valid = s_lbp_valid;
         if (abort_after > 0 && accepts == abort_after) begin
            s_start = 1'b0;
            return;
         end
         tick();
         if (n_fin > 0 && !s_finish) begin
            busy_after = int'(s_busy);
            break;
         end
      end
      s_start = 1'b0;
   endtask

   task automatic check_seq(input string name);
      check({name, "_len"}, got_q.size(), 28);
      for (int i = 0; i < 28; i++)
         check($sformatf("%s_seq%0d", name, i), (i < got_q.size()) ? got_q[i] : -1, exp_seq[i]);
   endtask

   initial begin
      s_reset = 0; s_start = 0; s_gray_ready = 0; s_lbp_ready = 0;
      b_reset = 0; b_start = 0; b_gray_ready = 1; b_lbp_ready = 1;
      @(negedge clk);
      #1;
      check("reset_outputs", 32'({s_gray_req, s_gray_addr, s_pix_we, s_pix_row,
                                  s_lbp_valid, s_lbp_addr, s_busy, s_finish}), 0);
      tick();
      s_reset = 1; b_reset = 1;
      tick();
      check("idle_busy", int'(s_busy), 0);
      b_start = 1;
      tick();
      b_start = 0;

      // Free-running small frame
      run_small(0, 0, 0, 0);
      check_seq("t1");
      check("t1_first_valid_cyc", first_valid_cyc, 11);
      check("t1_second_after_acc", second_valid_cyc - first_acc_cyc, 5);
      check("t1_finish_count", n_fin, 1);
      check("t1_busy_after", busy_after, 0);
      check("t1_pix_we_row", pix_bad, 0);
      check("t1_overlap", overlap_bad, 0);
      tick();

      // Random gray stalls plus start pokes while busy
      run_small(1, 0, 1, 0);
      check_seq("t2");
      check("t2_addr_hold", hold_addr_bad, 0);
      check("t2_pix_we_row", pix_bad, 0);
      check("t2_overlap", overlap_bad, 0);
      check("t2_finish_count", n_fin, 1);
      tick();

      // Result sink stalls 20 cycles on the first result
      run_small(0, 1, 0, 0);
      check_seq("t3");
      check("t3_hold_cycles", hold_cnt, 20);
      check("t3_hold_stable", hold_bad, 0);
      check("t3_read_delay", read_after_acc, 1);
      check("t3_read_addr", first_read_addr, 3);
      check("t3_finish_count", n_fin, 1);
      tick();

      // Reset mid-READ of the second row
      run_small(0, 0, 0, 15);
      check("t4_mid_read", int'(s_gray_req), 1);
      s_reset = 0;
      #1;
      check("t4_reset_outputs", 32'({s_gray_req, s_gray_addr, s_pix_we, s_pix_row,
                                     s_lbp_valid, s_lbp_addr, s_busy, s_finish}), 0);
      @(negedge clk);
      s_start = 1;
      tick();
      s_start = 0;
      check("t4_held_in_reset", 32'({s_busy, s_finish, s_gray_req}), 0);
      s_reset = 1;
      tick();
      check("t4_idle_after_release", int'(s_busy), 0);
      run_small(0, 0, 0, 0);
      check_seq("t4");
      check("t4_finish_count", n_fin, 1);

      // Full default-size frame
      for (int i = 0; i < 90000 && b_fin == 0; i++) tick();
      tick();
      tick();
      check("big_result_count", b_cnt, 15876);
      check("big_last_addr", b_last, 16254);
      check("big_finish_count", b_fin, 1);
      check("big_busy_after", int'(b_busy), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
